if_fetch_queue: RTL
===================

// Module: if_fetch_queue
// PURPOSE
//  Parametrised successor to the single-PC fetch stage. Owns the PC and drives a
//  one-outstanding-request imem read handshake. Buffers fetched {pc, instr} pairs
//  in a FQ_DEPTH-entry FIFO ahead of decode, so decode stalls no longer freeze fetch.
//  Takes EX-stage redirects (branch/jal/jalr). A redirect flushes the queue and any in-flight fetch.
// PARAMETERS
//  XLEN      32            data/address width
//  FQ_DEPTH  4             fetch-queue entries; power of 2, >=2
//  RESET_PC  32'h4000_0060 PC value after reset
// PORTS
//  clk              in   1     clock
//  rst              in   1     synchronous reset, active-high
//  redirect_valid   in   1     EX redirect (taken branch / jal / jalr) this cycle
//  redirect_target  in   XLEN  redirect address (alu_out)
//  redirect_mod2    in   1     1: clear target bit 0 (jalr)
//  imem_read        out  1     read request; held until imem_resp
//  imem_address     out  XLEN  request address; stable while imem_read=1
//  imem_resp        in   1     one-cycle response strobe
//  imem_rdata       in   XLEN  instruction; valid with imem_resp
//  if_valid         out  1     queue head valid
//  if_ready         in   1     decode accepts head (pop when if_valid & if_ready)
//  if_pc            out  XLEN  head PC
//  if_instr         out  XLEN  head instruction
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, state=IDLE, count=0, imem_read=0, if_valid=0; regs in rst branch.
//  Regs: fetch_pc (next PC to request); req_addr (in-flight address); imem_address=req_addr.
//  FSM IDLE / WAIT / DISCARD; imem_read=1 in WAIT and DISCARD only.
//   IDLE:  if !redirect & count<FQ_DEPTH -> req_addr<=fetch_pc, WAIT.
//   WAIT:  on imem_resp -> push {req_addr, imem_rdata}; fetch_pc<=req_addr+4.
//          If count_next<FQ_DEPTH, req_addr<=req_addr+4 and stay WAIT
//          (back-to-back, no bubble); else IDLE.
//   DISCARD: in-flight resp belongs to a dead path. On imem_resp: drop data,
//          req_addr<=fetch_pc, WAIT (queue empty after flush, so room exists).
//  count_next = count + push - pop. Issue only with a free slot reserved, so push never hits a full queue.
//  Redirect (highest priority): tgt = redirect_mod2 ? {target[XLEN-1:1],1'b0} : target.
//   Queue flushed (count<=0, ptrs<=0). Same-cycle pop and push are both cancelled.
//   fetch_pc<=tgt. Next state:
//    IDLE -> IDLE (request tgt next cycle)
//    WAIT, no resp -> DISCARD
//    WAIT with resp -> resp dropped; req_addr<=tgt, WAIT
//    DISCARD, no resp -> stays DISCARD; fetch_pc updated
//    DISCARD with resp -> req_addr<=tgt, WAIT
//  Redirect->first new instr at if_valid: 2 cycles + imem latency (IDLE case).
//  Output: if_valid=(count!=0); if_pc/if_instr come from head, combinationally from regs.
//   Head is held stable while if_valid & !if_ready.
//  Arithmetic: PC +4 wraps modulo 2^XLEN. Target bits[1:0] pass through unchanged (no alignment trap).
//  Push+pop same cycle: count unchanged, both pointers advance. Pointers wrap modulo FQ_DEPTH.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs perf_stall_cyc, perf_full_cyc, perf_redirects.
//   Each is 32 bits, saturating, 0 on rst.
//   perf_stall_cyc: cycles in WAIT/DISCARD with !imem_resp.
//   perf_full_cyc:  cycles with count==FQ_DEPTH.
//   perf_redirects: redirect_valid pulses.
//  IF_PERF_CNT_EN undefined: these ports and their logic do not exist; all other behaviour is identical.
// TESTING
//  1 rst 2 cycles -> imem_read=0, if_valid=0. Cycle after rst release: imem_read=1, imem_address=0x4000_0060.
//  2 Memory returns resp every cycle, if_ready=1 -> addresses 0x60,0x64,0x68... on consecutive cycles.
//    imem_read stays high; if_pc follows in order.
//  3 if_ready=0, same memory -> 4 pushes, count=4, imem_read drops to 0; head pc stays 0x4000_0060.
//    Raise if_ready -> one pop, then refill.
//  4 Redirect tgt 0x4000_0100 while WAIT, resp 3 cycles later with 0xDEAD_BEEF -> data never appears.
//    if_valid=0 until new fetch; next imem_address=0x4000_0100.
//  5 Redirect mod2=1 tgt 0x4000_0123 in the same cycle as imem_resp -> resp dropped.
//    Next cycle imem_address=0x4000_0122; queue empty.
//  6 IF_PERF_CNT_EN: 3 redirects with 2-cycle imem latency -> perf_redirects=3.
//    perf_stall_cyc equals counted no-resp request cycles.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Fetch stage: owns the PC and a one-outstanding imem read, and buffers {pc, instr} in an FQ_DEPTH queue ahead of decode. Optional perf counters under IF_PERF_CNT_EN.
// Latency: a redirect reaches if_valid after 2 cycles + imem latency; requests go back-to-back while a queue slot stays free.
// Backpressure: decode pops on if_valid & if_ready; a request is only issued with a slot reserved, so a full queue parks fetch in IDLE.
module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              FQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h4000_0060
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            redirect_mod2,
    output logic            imem_read,
    output logic [XLEN-1:0] imem_address,
    input  logic            imem_resp,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cyc,
    output logic [31:0]     perf_full_cyc,
    output logic [31:0]     perf_redirects
`endif
);

    localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fq_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DISCARD
    } state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_addr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    fq_entry_t       fq_mem [FQ_DEPTH];

    logic            push;
    logic            pop;
    logic            room_next;
    logic [XLEN-1:0] redirect_tgt;

    assign redirect_tgt = redirect_mod2 ? {redirect_target[XLEN-1:1], 1'b0} : redirect_target;
    assign pop          = (count != '0) && if_ready;
    assign push         = (state == ST_WAIT) && imem_resp;
    assign count_next   = count + CW'(push) - CW'(pop);
    assign room_next    = count_next < CW'(FQ_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            fetch_pc  <= RESET_PC;
            req_addr  <= RESET_PC;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            imem_read <= 1'b0;
        end else if (redirect_valid) begin
            // Flush wins over any same-cycle push/pop; an in-flight read without
            // its response must still be absorbed, hence DISCARD.
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fetch_pc <= redirect_tgt;
            if (state == ST_IDLE) begin
                state     <= ST_IDLE;
                imem_read <= 1'b0;
            end else if (imem_resp) begin
                req_addr  <= redirect_tgt;
                state     <= ST_WAIT;
                imem_read <= 1'b1;
            end else begin
                state     <= ST_DISCARD;
                imem_read <= 1'b1;
            end
        end else begin
            count <= count_next;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case (state)
                ST_IDLE: begin
                    if (count < CW'(FQ_DEPTH)) begin
                        req_addr  <= fetch_pc;
                        state     <= ST_WAIT;
                        imem_read <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp) begin
                        fetch_pc <= req_addr + XLEN'(4);
                        if (room_next) begin
                            req_addr <= req_addr + XLEN'(4);
                        end else begin
                            state     <= ST_IDLE;
                            imem_read <= 1'b0;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (imem_resp) begin
                        req_addr <= fetch_pc;
                        state    <= ST_WAIT;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    imem_read <= 1'b0;
                end
            endcase
        end
    end

    // Queue payload carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !redirect_valid && !rst) begin
            fq_mem[wr_ptr] <= fq_entry_t'{pc: req_addr, instr: imem_rdata};
        end
    end

    assign imem_address = req_addr;
    assign if_valid     = (count != '0);
    assign if_pc        = fq_mem[rd_ptr].pc;
    assign if_instr     = fq_mem[rd_ptr].instr;

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cyc <= '0;
            perf_full_cyc  <= '0;
            perf_redirects <= '0;
        end else begin
            if ((state != ST_IDLE) && !imem_resp && (perf_stall_cyc != '1))
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if ((count == CW'(FQ_DEPTH)) && (perf_full_cyc != '1))
                perf_full_cyc <= perf_full_cyc + 32'd1;
            if (redirect_valid && (perf_redirects != '1))
                perf_redirects <= perf_redirects + 32'd1;
        end
    end
`endif

endmodule
